// File: rtl/rename_reg_file_if.sv
// rename_reg_file_if: Dispatcher/ROB-facing bus of the rename register file.
//   rdy                                     global ready, low holds state
//   commit_en / commit_value / commit_rob_id ROB commit of a register write
//   flush                                   mispredict, drops all rename tags
//   rs1 / rs2 -> Qj,Vj / Qk,Vk              operand lookup
//   rename_en / rename_rd / rename_rob_id   destination rename
//   pending_cnt                             registers holding a live tag
// master = ROB/Dispatcher side, slave = register file.
interface rename_reg_file_if #(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 5
);
    logic                rdy;
    logic                commit_en;
    logic [DATA_W-1:0]   commit_value;
    logic [ROB_ID_W-1:0] commit_rob_id;
    logic                flush;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [ROB_ID_W-1:0] Qj;
    logic [ROB_ID_W-1:0] Qk;
    logic [DATA_W-1:0]   Vj;
    logic [DATA_W-1:0]   Vk;
    logic                rename_en;
    logic [4:0]          rename_rd;
    logic [ROB_ID_W-1:0] rename_rob_id;
    logic [5:0]          pending_cnt;

    modport master (
        output rdy, commit_en, commit_value, commit_rob_id, flush,
               rs1, rs2, rename_en, rename_rd, rename_rob_id,
        input  Qj, Qk, Vj, Vk, pending_cnt
    );

    modport slave (
        input  rdy, commit_en, commit_value, commit_rob_id, flush,
               rs1, rs2, rename_en, rename_rd, rename_rob_id,
        output Qj, Qk, Vj, Vk, pending_cnt
    );
endinterface

// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with per-register rename tags.
//   clk, rst    clock, synchronous active-high reset
//   bus (slave) commit, flush, operand lookup, rename and pending_cnt
// Each register keeps its committed value and the ROB id of its youngest
// in-flight producer (NON_DEP when none). x0 always reads NON_DEP / 0.
// Build option: define RENAME_REG_FILE_BYPASS_EN to forward a same-cycle
// commit onto the read ports; otherwise reads return pre-commit state.
module rename_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 5,
    parameter int NON_DEP  = 16,
    parameter int REG_NUM  = 32
) (
    input logic               clk,
    input logic               rst,
    rename_reg_file_if.slave  bus
);
    localparam logic [ROB_ID_W-1:0] NON_TAG = ROB_ID_W'(NON_DEP);

    logic [DATA_W-1:0]   val     [REG_NUM];
    logic [ROB_ID_W-1:0] tag     [REG_NUM];
    logic [DATA_W-1:0]   val_nxt [REG_NUM];
    logic [ROB_ID_W-1:0] tag_nxt [REG_NUM];
    logic [REG_NUM-1:0]  match_v;
    logic [REG_NUM-1:0]  ren_v;
    logic [5:0]          cnt;
    logic [5:0]          cnt_nxt;
    logic [5:0]          dec;
    logic                inc;

    // A commit only lands on a register whose youngest producer is the
    // committing entry; an older producer's commit is superseded. A rename
    // in the same cycle wins the tag but the value is still written.
    always_comb begin
        match_v = '0;
        ren_v   = '0;
        dec     = '0;
        for (int r = 0; r < REG_NUM; r++) begin
            match_v[r] = bus.commit_en && r != 0 && tag[r] != NON_TAG && tag[r] == bus.commit_rob_id;
            ren_v[r]   = bus.rename_en && r != 0 && bus.rename_rd == 5'(r);
            val_nxt[r] = match_v[r] ? bus.commit_value : val[r];
            tag_nxt[r] = ren_v[r] ? bus.rename_rob_id : (match_v[r] ? NON_TAG : tag[r]);
            dec        = dec + 6'(match_v[r] && !ren_v[r]);
        end
        inc     = bus.rename_en && bus.rename_rd != '0 && tag[bus.rename_rd] == NON_TAG;
        cnt_nxt = cnt + 6'(inc) - dec;
    end

    // Flush still takes the commit value (final JAL/JALR commit) and
    // overrides rdy; rdy low otherwise freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                val[r] <= '0;
                tag[r] <= NON_TAG;
            end
            cnt <= '0;
        end else if (bus.flush) begin
            for (int r = 0; r < REG_NUM; r++) begin
                val[r] <= val_nxt[r];
                tag[r] <= NON_TAG;
            end
            cnt <= '0;
        end else if (bus.rdy) begin
            for (int r = 0; r < REG_NUM; r++) begin
                val[r] <= val_nxt[r];
                tag[r] <= tag_nxt[r];
            end
            cnt <= cnt_nxt;
        end
    end

    // Read ports: a same-cycle rename is intentionally invisible here.
`ifdef RENAME_REG_FILE_BYPASS_EN
    always_comb begin
        bus.Qj = bus.rs1 == '0 ? NON_TAG : (match_v[bus.rs1] ? NON_TAG : tag[bus.rs1]);
        bus.Vj = bus.rs1 == '0 ? '0 : (match_v[bus.rs1] ? bus.commit_value : val[bus.rs1]);
        bus.Qk = bus.rs2 == '0 ? NON_TAG : (match_v[bus.rs2] ? NON_TAG : tag[bus.rs2]);
        bus.Vk = bus.rs2 == '0 ? '0 : (match_v[bus.rs2] ? bus.commit_value : val[bus.rs2]);
    end
`else
    always_comb begin
        bus.Qj = bus.rs1 == '0 ? NON_TAG : tag[bus.rs1];
        bus.Vj = bus.rs1 == '0 ? '0 : val[bus.rs1];
        bus.Qk = bus.rs2 == '0 ? NON_TAG : tag[bus.rs2];
        bus.Vk = bus.rs2 == '0 ? '0 : val[bus.rs2];
    end
`endif

    assign bus.pending_cnt = cnt;
endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Architectural register file with per-register rename tags for the Tomasulo core.
- Receiving end of the ROB commit interface (enable / value / ROB id) and the mispredict flush.
- Serves operand lookup and destination renaming to the Dispatcher.
- Each register holds a committed value plus the ROB id of its youngest in-flight producer, or NON_DEP when no producer is in flight.

Parameters:
- DATA_W, 32, register/data width
- ROB_ID_W, 5, ROB id width
- NON_DEP, 16, tag meaning "no in-flight producer"; never a valid ROB id
- REG_NUM, 32, number of architectural registers (x0..x31)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low = hold all state
- commit_en  in  1  ROB commits a register-writing instruction this cycle
- commit_value  in  DATA_W  committed result
- commit_rob_id  in  ROB_ID_W  ROB id of the committing entry
- flush  in  1  mispredict; drop all rename tags
- rs1, rs2  in  5  Dispatcher source register indices
- Qj, Qk  out  ROB_ID_W  producer tag for rs1/rs2, or NON_DEP
- Vj, Vk  out  DATA_W  committed value for rs1/rs2 (meaningful when Q==NON_DEP)
- rename_en  in  1  Dispatcher issues an instruction writing rename_rd
- rename_rd  in  5  destination register
- rename_rob_id  in  ROB_ID_W  ROB id allocated to that instruction
- pending_cnt  out  6  number of registers currently holding a tag != NON_DEP

Behaviour:
- State: val[0..31], tag[0..31], pending_cnt counter.
- Reset:
  - all val = 0, all tag = NON_DEP, pending_cnt = 0.
  - Q/V outputs then read Q=NON_DEP, V=0.
- Priority per cycle: rst > flush > !rdy (hold) > normal.
- Commit (posedge, commit_en):
  - For every r in 1..31 with tag[r]==commit_rob_id: val[r] <= commit_value.
  - Also tag[r] <= NON_DEP, unless renamed the same cycle (below).
  - If no tag matches, val is unchanged: the register was already renamed to a younger producer and the write is superseded.
  - At most one register can match by construction; all matches are handled regardless.
- Rename (posedge, rename_en, rename_rd!=0): tag[rename_rd] <= rename_rob_id.
- Commit and rename on the same register, same cycle:
  - val takes commit_value (if the old tag matched).
  - tag takes rename_rob_id; rename wins.
- x0: val and tag are never written; reads always give Q=NON_DEP, V=0. Rename to x0 is ignored and does not change pending_cnt.
- Flush cycle:
  - Commit is still applied to val; the ROB raises mispredict alongside the final JAL/JALR commit.
  - Then all tags <= NON_DEP and pending_cnt <= 0.
  - rename_en is ignored.
  - Flush acts even when rdy is low.
- rdy low (no rst/flush): val, tag and pending_cnt hold; reads still combinational.
- pending_cnt:
  - +1 when a rename moves a register from NON_DEP to a tag.
  - -1 when a commit clears a tag not simultaneously renamed.
  - Both in one cycle on different registers: net 0.
  - Range 0..31; never wraps.
- Read ports (combinational, zero latency):
  - Q = tag[rs], V = val[rs].
  - With bypass (see Optional Feature): if commit_en and tag[rs]==commit_rob_id and rs!=0, then Q = NON_DEP, V = commit_value.
  - A same-cycle rename is NOT visible on the read ports. The Dispatcher orders the read before the rename of the same instruction.
- Width rules: no arithmetic on val. Tag compare is full ROB_ID_W equality. NON_DEP never equals a live ROB id.

Optional Feature:
- Macro: RENAME_REG_FILE_BYPASS_EN.
- Defined: the same-cycle commit-to-read bypass described above is built.
- Undefined:
  - Read ports return the pre-commit tag/value.
  - The Dispatcher picks the value up from the ROB ready/result path instead.
  - Zero-cycle path from commit_value to Vj/Vk is removed for timing.

Test Plan:
- Reset then read rs1=5, rs2=0 -> Qj=16, Vj=0, Qk=16, Vk=0, pending_cnt=0.
- rename x5->id 3; next cycle commit id 3 with value 0xDEADBEEF; then read x5 -> pending_cnt 1 then 0; x5 reads Q=16, V=0xDEADBEEF.
- rename x7->id 2, then x7->id 4; commit id 2 value 0x11 -> x7 keeps tag 4, V unchanged (0). Commit id 4 value 0x22 -> x7 Q=16, V=0x22.
- Same cycle: commit id 1 (x9 tagged 1) value 0x55 and rename x9->id 6 -> x9 V=0x55, Q=6, pending_cnt unchanged.
- x10/x11/x12 tagged; flush with commit of x10's id value 0x99 and rename x13 -> all Q=16, x10 V=0x99, x13 untagged, pending_cnt=0.
- With BYPASS_EN: x3 tagged 8, commit id 8 value 0x1234 while rs1=3 -> same cycle Qj=16, Vj=0x1234. Without the macro: Qj=8 that cycle, Qj=16 the next. Also rdy=0 holds rename/commit effects until rdy=1.
